noc_vc_input_buffer: RTL

Parametrised next-generation router input buffer: one input link feeding NUM_VC independent virtual-channel FIFOs, each DEPTH flits deep. Exposes first-word-fall-through heads to the router's switch allocator. Returns one credit per dequeued flit to the upstream router. Tracks per-VC packet framing and flags overflow and protocol errors. Sits between the link receiver and the crossbar/allocator of each router port.

---
 rtl/noc_vc_input_buffer.sv | 190 +++++++++++++++++++
 1 files changed

// File: rtl/noc_vc_input_buffer.sv
// Router input buffer: one link demultiplexed into NUM_VC first-word-fall-through
// FIFOs with per-VC credit return, packet framing tracking and sticky error flags.
`timescale 1ns/1ps

module noc_vc_input_buffer #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned NUM_VC = 2,
  parameter int unsigned DEPTH  = 4,
  localparam int unsigned CNT_W = $clog2(DEPTH + 1),
  localparam int unsigned VC_W  = (NUM_VC > 1) ? $clog2(NUM_VC) : 1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  input  logic [VC_W-1:0]            in_vc,
  input  logic [1:0]                 in_type,
  input  logic [DATA_W-1:0]          in_data,
  input  logic [NUM_VC-1:0]          rd_en,
  output logic [NUM_VC-1:0]          out_valid,
  output logic [2*NUM_VC-1:0]        out_type,
  output logic [DATA_W*NUM_VC-1:0]   out_data,
  output logic [CNT_W*NUM_VC-1:0]    occupancy,
  output logic [NUM_VC-1:0]          credit_out,
  output logic                       overflow_err,
  output logic                       proto_err
);

  localparam int unsigned PTR_W = $clog2(DEPTH);

  localparam logic [1:0] T_BODY = 2'b00;
  localparam logic [1:0] T_HEAD = 2'b01;
  localparam logic [1:0] T_TAIL = 2'b10;
  localparam logic [1:0] T_HT   = 2'b11;

  typedef struct packed {
    logic [1:0]        ftype;
    logic [DATA_W-1:0] data;
  } flit_t;

  typedef enum logic {
    F_IDLE   = 1'b0,
    F_ACTIVE = 1'b1
  } frame_t;

  flit_t            mem    [NUM_VC][DEPTH];
  logic [PTR_W-1:0] rd_ptr [NUM_VC];
  logic [PTR_W-1:0] wr_ptr [NUM_VC];
  logic [CNT_W-1:0] cnt    [NUM_VC];
  frame_t           frame_q[NUM_VC];
  frame_t           frame_d[NUM_VC];

  logic [NUM_VC-1:0] wr_hit;
  logic [NUM_VC-1:0] empty;
  logic [NUM_VC-1:0] full;
  logic [NUM_VC-1:0] pop;
  logic [NUM_VC-1:0] push;
  logic [NUM_VC-1:0] drop;
  logic [NUM_VC-1:0] frame_viol;
  logic              vc_bad;

  // Per-VC write/read qualification; a full VC still accepts when it pops in the same cycle.
  always_comb begin
    vc_bad = in_valid && (32'(in_vc) >= NUM_VC);
    wr_hit = '0;
    empty  = '0;
    full   = '0;
    pop    = '0;
    push   = '0;
    drop   = '0;
    for (int v = 0; v < NUM_VC; v++) begin
      wr_hit[v] = in_valid && (32'(in_vc) == 32'(v));
      empty[v]  = (cnt[v] == '0);
      full[v]   = (cnt[v] == CNT_W'(DEPTH));
      pop[v]    = rd_en[v] && !empty[v];
      push[v]   = wr_hit[v] && (!full[v] || pop[v]);
      drop[v]   = wr_hit[v] && full[v] && !pop[v];
    end
  end

  // Framing next state: every write aimed at a VC (stored or dropped) advances its tracker.
  always_comb begin
    frame_viol = '0;
    for (int v = 0; v < NUM_VC; v++) begin
      frame_d[v] = frame_q[v];
      if (wr_hit[v]) begin
        case (frame_q[v])
          F_IDLE: begin
            case (in_type)
              T_HEAD:  frame_d[v] = F_ACTIVE;
              T_HT:    frame_d[v] = F_IDLE;
              default: frame_viol[v] = 1'b1;
            endcase
          end
          F_ACTIVE: begin
            case (in_type)
              T_BODY: frame_d[v] = F_ACTIVE;
              T_TAIL: frame_d[v] = F_IDLE;
              T_HEAD: begin
                frame_viol[v] = 1'b1;
                frame_d[v]    = F_ACTIVE;
              end
              default: begin
                frame_viol[v] = 1'b1;
                frame_d[v]    = F_IDLE;
              end
            endcase
          end
          default: frame_d[v] = F_IDLE;
        endcase
      end
    end
  end

  // Framing state register per VC.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int v = 0; v < NUM_VC; v++) begin
        frame_q[v] <= F_IDLE;
      end
    end else begin
      for (int v = 0; v < NUM_VC; v++) begin
        frame_q[v] <= frame_d[v];
      end
    end
  end

  // Pointers and occupancy; pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int v = 0; v < NUM_VC; v++) begin
        rd_ptr[v] <= '0;
        wr_ptr[v] <= '0;
        cnt[v]    <= '0;
      end
    end else begin
      for (int v = 0; v < NUM_VC; v++) begin
        if (push[v]) begin
          wr_ptr[v] <= wr_ptr[v] + PTR_W'(1);
        end
        if (pop[v]) begin
          rd_ptr[v] <= rd_ptr[v] + PTR_W'(1);
        end
        if (push[v] && !pop[v]) begin
          cnt[v] <= cnt[v] + CNT_W'(1);
        end else if (!push[v] && pop[v]) begin
          cnt[v] <= cnt[v] - CNT_W'(1);
        end
      end
    end
  end

  // Flit storage; contents are masked at the outputs while a VC is empty, so no reset needed.
  always_ff @(posedge clk) begin
    for (int v = 0; v < NUM_VC; v++) begin
      if (push[v]) begin
        mem[v][wr_ptr[v]] <= '{ftype: in_type, data: in_data};
      end
    end
  end

  // Credit pulses and sticky error flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      credit_out   <= '0;
      overflow_err <= 1'b0;
      proto_err    <= 1'b0;
    end else begin
      credit_out   <= pop;
      overflow_err <= overflow_err | (|drop);
      proto_err    <= proto_err | (|frame_viol) | vc_bad;
    end
  end

  // FWFT head presentation and occupancy export.
  always_comb begin
    out_valid = '0;
    out_type  = '0;
    out_data  = '0;
    occupancy = '0;
    for (int v = 0; v < NUM_VC; v++) begin
      occupancy[CNT_W*v +: CNT_W] = cnt[v];
      if (!empty[v]) begin
        out_valid[v]                  = 1'b1;
        out_type[2*v +: 2]            = mem[v][rd_ptr[v]].ftype;
        out_data[DATA_W*v +: DATA_W]  = mem[v][rd_ptr[v]].data;
      end
    end
  end

endmodule
